// File: rtl/regfile_alu_seq.sv
// Parametrised register file with program/load and execute paths over eight ALU ops,
// including an iterative shift-add multiply, behind a go/busy/done handshake.
`timescale 1ns/1ps
module regfile_alu_seq #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              program_i,
  input  logic              load_i,
  input  logic              go_i,
  input  logic [REG_AW-1:0] register_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] q_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              carry_o,
  output logic              zero_o
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   rd_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [2*DATA_W-1:0] mcand_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   q_q;
  logic                done_q;
  logic                carry_q;
  logic                zero_q;

  logic [DATA_W-1:0]   result_d;
  logic                carry_d;
  logic [DATA_W:0]     wide_d;

  // MUL reuses the EXEC write-back: the finished product is selected here once the
  // shift-add loop has handed control over to EXEC.
  always_comb begin
    wide_d   = '0;
    result_d = '0;
    carry_d  = 1'b0;
    case (op_q)
      3'b000: begin
        wide_d   = {1'b0, a_q} + {1'b0, b_q};
        result_d = wide_d[DATA_W-1:0];
        carry_d  = wide_d[DATA_W];
      end
      3'b001: begin
        wide_d   = {1'b0, a_q} - {1'b0, b_q};
        result_d = wide_d[DATA_W-1:0];
        carry_d  = wide_d[DATA_W];
      end
      3'b010: result_d = a_q & b_q;
      3'b011: result_d = a_q | b_q;
      3'b100: result_d = a_q ^ b_q;
      3'b101: begin
        result_d = a_q << 1;
        carry_d  = a_q[DATA_W-1];
      end
      3'b110: begin
        result_d = a_q >> 1;
        carry_d  = a_q[0];
      end
      default: begin
        result_d = prod_q[DATA_W-1:0];
        carry_d  = |prod_q[2*DATA_W-1:DATA_W];
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (program_i) begin
            if (load_i) begin
              regs_q[register_i] <= data_i;
              q_q                <= data_i;
            end
          end else if (go_i) begin
            op_q    <= op_i;
            rd_q    <= register_i;
            a_q     <= regs_q[register_i];
            b_q     <= regs_q[src_i];
            prod_q  <= '0;
            mcand_q <= {{DATA_W{1'b0}}, regs_q[register_i]};
            cnt_q   <= '0;
            state_q <= (op_i == 3'b111) ? MUL : EXEC;
          end
        end
        MUL: begin
          // One multiplier bit per cycle; b_q is consumed LSB-first.
          if (b_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q <= mcand_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= EXEC;
        end
        EXEC: begin
          regs_q[rd_q] <= result_d;
          q_q          <= result_d;
          carry_q      <= carry_d;
          zero_q       <= (result_d == '0);
          done_q       <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q_o     = q_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign carry_o = carry_q;
  assign zero_o  = zero_q;

endmodule
